// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg: opcode/state encodings shared by the execute stage. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    WAIT = 2'b10,
    WB   = 2'b11
  } exec_state_t;

  // Sliced down to the datapath width at the point of use.
  localparam logic [63:0] ERR_RESULT = '1;

endpackage

`default_nettype wire

// File: rtl/exec_timeout_ctr.sv
// ----------------------------------------------------------------------------
// exec_timeout_ctr: clear/enable up-counter with terminal-count flag. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module exec_timeout_ctr
  import cpu_pkg::*;
#(
  parameter int CNT_W    = 6,
  parameter int TERMINAL = 63
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = en && (count == CNT_W'(TERMINAL));

endmodule

`default_nettype wire

// File: rtl/alu_exec_sequencer.sv
// ----------------------------------------------------------------------------
// alu_exec_sequencer: execute-stage controller for add/sub/mul/div units. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_exec_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int RADDR_W     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_opcode,
  input  logic [RADDR_W-1:0] in_rd_addr,
  input  logic [DATA_W-1:0]  in_rs1_val,
  input  logic [DATA_W-1:0]  in_rs2_val,
  output logic [DATA_W-1:0]  op_a,
  output logic [DATA_W-1:0]  op_b,
  output logic               mul_start,
  input  logic               mul_done,
  output logic               div_start,
  input  logic               div_done,
  output logic [1:0]         out_opcode,
  input  logic [DATA_W-1:0]  rd_val,
  output logic               wb_valid,
  input  logic               wb_ready,
  output logic [RADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]  wb_data,
  output logic               exec_err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [DATA_W-1:0] ERR_DATA = ERR_RESULT[DATA_W-1:0];

  exec_state_t state;
  opcode_t     opcode_q;
  logic        cnt_en;
  logic        cnt_clr;
  logic        cnt_tc;
  logic        done_hit;

  assign cnt_en     = (state == WAIT);
  assign cnt_clr    = !cnt_en;
  assign out_opcode = opcode_q;

  exec_timeout_ctr #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYC - 1)
  ) u_timeout_ctr (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  // Only the unit that was actually started may complete the op.
  always_comb begin
    done_hit = 1'b0;
    case (opcode_q)
      OP_MUL:  done_hit = mul_done;
      OP_DIV:  done_hit = div_done;
      default: done_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      opcode_q  <= OP_ADD;
      op_a      <= '0;
      op_b      <= '0;
      mul_start <= 1'b0;
      div_start <= 1'b0;
      wb_valid  <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      exec_err  <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      div_start <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            opcode_q <= opcode_t'(in_opcode);
            wb_addr  <= in_rd_addr;
            op_a     <= in_rs1_val;
            op_b     <= in_rs2_val;
            in_ready <= 1'b0;
            case (opcode_t'(in_opcode))
              OP_ADD, OP_SUB: state <= EXEC;
              OP_MUL: begin
                state     <= WAIT;
                mul_start <= 1'b1;
              end
              default: begin
                // Divide by zero never reaches the divider.
                if (in_rs2_val == '0) begin
                  state    <= WB;
                  wb_valid <= 1'b1;
                  wb_data  <= ERR_DATA;
                  exec_err <= 1'b1;
                end else begin
                  state     <= WAIT;
                  div_start <= 1'b1;
                end
              end
            endcase
          end
        end
        EXEC: begin
          wb_data  <= rd_val;
          exec_err <= 1'b0;
          wb_valid <= 1'b1;
          state    <= WB;
        end
        WAIT: begin
          // A done coinciding with terminal count still yields the real result.
          if (done_hit) begin
            wb_data  <= rd_val;
            exec_err <= 1'b0;
            wb_valid <= 1'b1;
            state    <= WB;
          end else if (cnt_tc) begin
            wb_data  <= ERR_DATA;
            exec_err <= 1'b1;
            wb_valid <= 1'b1;
            state    <= WB;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            exec_err <= 1'b0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          wb_valid <= 1'b0;
          exec_err <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
